// File: rtl/sort_sched_pkg.sv
// Shared types, constants and the wrap-safe time compare for the sort-pulse scheduler.
package sort_sched_pkg;

  localparam int TSW_DEF   = 32;
  localparam int MIN_DELAY = 2;
  localparam int CMP_W     = 64;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_FIRE = 2'd2
  } state_e;

  typedef struct packed {
    logic [TSW_DEF-1:0] f;
    logic [TSW_DEF-1:0] dur;
  } entry_t;

  // True when a lies before b on a wrapping timeline of msb+1 bits (operands zero-extended).
  function automatic logic time_before(input logic [CMP_W-1:0] a,
                                       input logic [CMP_W-1:0] b,
                                       input logic [5:0]       msb);
    logic [CMP_W-1:0] diff;
    diff = a - b;
    return diff[msb];
  endfunction

endpackage

// File: rtl/red_pitaya_sort_scheduler_if.sv
// Request/config bundle driven by the FADS evaluation FSM into the sort scheduler.
// req is a one-cycle strobe qualified by enable; there is no backpressure, the outcome is reported by the counters.
interface red_pitaya_sort_scheduler_if #(parameter int TSW = 32);
  logic           enable;
  logic           req;
  logic           flush;
  logic [TSW-1:0] sort_delay;
  logic [TSW-1:0] sort_duration;
  logic [TSW-1:0] guard;

  modport master (output enable, req, flush, sort_delay, sort_duration, guard);
  modport slave  (input  enable, req, flush, sort_delay, sort_duration, guard);
endinterface

// File: rtl/sort_sched_fifo.sv
// First-word-fall-through FIFO of 2^QSZ fire entries with synchronous flush.
module sort_sched_fifo #(
  parameter int QSZ = 3,
  parameter int W   = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] head_o,
  output logic [QSZ:0] level_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int DEPTH = 1 << QSZ;

  logic [W-1:0]   mem_q [DEPTH];
  logic [QSZ-1:0] wr_ptr_q, rd_ptr_q;
  logic [QSZ:0]   level_q;
  logic           do_push, do_pop;

  assign full_o  = (level_q == (QSZ+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_q + {{QSZ{1'b0}}, do_push} - {{QSZ{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end
endmodule

// File: rtl/red_pitaya_sort_scheduler.sv
// Timestamped sort-pulse scheduler owning the single sort trigger.
// Optional SORT_SCHED_DEBUG_EN drives debug_o with registered queue/state flags; otherwise debug_o is 0.
module red_pitaya_sort_scheduler
  import sort_sched_pkg::*;
#(
  parameter int QSZ = 3,
  parameter int TSW = TSW_DEF
) (
  input  logic                        adc_clk_i,
  input  logic                        adc_rst_i,
  red_pitaya_sort_scheduler_if.slave  cfg_if,
  output logic                        sort_trig_o,
  output logic                        busy_o,
  output logic [QSZ:0]                queue_level_o,
  output logic [TSW-1:0]              accepted_cnt_o,
  output logic [TSW-1:0]              drop_full_cnt_o,
  output logic [TSW-1:0]              drop_conflict_cnt_o,
  output logic [TSW-1:0]              fire_cnt_o,
  output logic [7:0]                  debug_o
);
  localparam logic [TSW-1:0] CNT_MAX = '1;

  state_e         state_q, state_d;
  logic [TSW-1:0] now_q, last_end_q, cnt_q, cnt_d;
  logic [TSW-1:0] acc_q, dfull_q, dconf_q, fire_q;
  logic           trig_q, trig_d;
  logic           pop, fire;

  logic [TSW-1:0]   eff_delay, fire_t, gap_ref, head_f, head_dur;
  logic [2*TSW-1:0] head;
  logic             req_ok, conflict, push, fifo_full, fifo_empty;

  assign eff_delay = (cfg_if.sort_delay < TSW'(MIN_DELAY)) ? TSW'(MIN_DELAY) : cfg_if.sort_delay;
  assign fire_t    = now_q + eff_delay;
  assign gap_ref   = last_end_q + cfg_if.guard;
  assign req_ok    = cfg_if.req && cfg_if.enable && !cfg_if.flush;
  assign conflict  = (cfg_if.sort_duration == '0) ||
                     time_before(CMP_W'(fire_t), CMP_W'(gap_ref), 6'(TSW-1));
  assign push      = req_ok && !conflict && !fifo_full;
  assign head_f    = head[2*TSW-1:TSW];
  assign head_dur  = head[TSW-1:0];

  sort_sched_fifo #(.QSZ(QSZ), .W(2*TSW)) u_fifo (
    .clk_i   (adc_clk_i),
    .rst_i   (adc_rst_i),
    .flush_i (cfg_if.flush),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   ({fire_t, cfg_if.sort_duration}),
    .head_o  (head),
    .level_o (queue_level_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    trig_d  = trig_q;
    pop     = 1'b0;
    fire    = 1'b0;
    if (cfg_if.flush) begin
      state_d = S_IDLE;
      trig_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: if (!fifo_empty) state_d = S_WAIT;
        S_WAIT: begin
          if (!fifo_empty && head_f == now_q) begin
            pop     = 1'b1;
            fire    = 1'b1;
            cnt_d   = head_dur;
            trig_d  = 1'b1;
            state_d = S_FIRE;
          end
        end
        S_FIRE: begin
          if (cnt_q == TSW'(1)) begin
            // A head due exactly now continues the pulse without a low cycle.
            if (!fifo_empty && head_f == now_q) begin
              pop   = 1'b1;
              fire  = 1'b1;
              cnt_d = head_dur;
            end else begin
              trig_d  = 1'b0;
              cnt_d   = '0;
              state_d = fifo_empty ? S_IDLE : S_WAIT;
            end
          end else begin
            cnt_d = cnt_q - TSW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i) begin
      state_q    <= S_IDLE;
      now_q      <= '0;
      last_end_q <= '0;
      cnt_q      <= '0;
      trig_q     <= 1'b0;
      acc_q      <= '0;
      dfull_q    <= '0;
      dconf_q    <= '0;
      fire_q     <= '0;
    end else begin
      state_q <= state_d;
      now_q   <= now_q + TSW'(1);
      cnt_q   <= cnt_d;
      trig_q  <= trig_d;
      if (cfg_if.flush)  last_end_q <= now_q;
      else if (push)     last_end_q <= fire_t + cfg_if.sort_duration;
      if (push && acc_q != CNT_MAX)                               acc_q   <= acc_q + TSW'(1);
      if (req_ok && conflict && dconf_q != CNT_MAX)               dconf_q <= dconf_q + TSW'(1);
      if (req_ok && !conflict && fifo_full && dfull_q != CNT_MAX) dfull_q <= dfull_q + TSW'(1);
      if (fire && fire_q != CNT_MAX)                              fire_q  <= fire_q + TSW'(1);
    end
  end

  assign sort_trig_o         = trig_q;
  assign busy_o              = (state_q != S_IDLE);
  assign accepted_cnt_o      = acc_q;
  assign drop_full_cnt_o     = dfull_q;
  assign drop_conflict_cnt_o = dconf_q;
  assign fire_cnt_o          = fire_q;

`ifdef SORT_SCHED_DEBUG_EN
  logic [7:0] debug_q;
  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i) debug_q <= '0;
    else debug_q <= {fifo_full, fifo_empty, 3'b000,
                     state_q == S_FIRE, state_q == S_WAIT, state_q == S_IDLE};
  end
  assign debug_o = debug_q;
`else
  assign debug_o = 8'h00;
`endif
endmodule
